// File: rtl/mnist_uart_pkg.sv
// Constants shared by the UART image transmitter and receiver: sync bytes,
// error and state encodings, and the byte-time / timeout derivation.
package mnist_uart_pkg;

  localparam logic [7:0] SYNC0_BYTE = 8'hA5;
  localparam logic [7:0] SYNC1_BYTE = 8'h5A;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_CSUM    = 2'd1,
    ERR_TIMEOUT = 2'd2
  } err_code_e;

  typedef enum logic [1:0] {
    S_SYNC0   = 2'd0,
    S_SYNC1   = 2'd1,
    S_PAYLOAD = 2'd2,
    S_CHECK   = 2'd3
  } rx_state_e;

  // One UART character is 10 bit-times (start + 8 data + stop).
  function automatic logic [31:0] byte_time_clks(input int clk_freq, input int bps);
    return 32'(clk_freq / bps) * 32'd10;
  endfunction

  function automatic logic [31:0] timeout_clks(input int clk_freq, input int bps,
                                               input int frames);
    return byte_time_clks(clk_freq, bps) * 32'(frames);
  endfunction

endpackage

// File: rtl/sat_counter16.sv
// 16-bit event counter that sticks at 16'hFFFF instead of wrapping.
module sat_counter16 (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        inc_i,
  output logic [15:0] cnt_o
);

  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/image_rx_framer.sv
// Receive framer: hunts the two-byte header, streams IMG_PIXELS payload bytes
// with their index, then checks the additive checksum. Line silence aborts.
module image_rx_framer
  import mnist_uart_pkg::*;
#(
  parameter int         IMG_PIXELS     = 784,
  parameter logic [7:0] SYNC0          = SYNC0_BYTE,
  parameter logic [7:0] SYNC1          = SYNC1_BYTE,
  parameter int         UART_BPS       = 115200,
  parameter int         CLK_FREQ       = 50_000_000,
  parameter int         TIMEOUT_FRAMES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  pix_data,
  output logic        pix_valid,
  output logic [9:0]  pix_index,
  output logic        frame_start,
  output logic        frame_done,
  output logic        frame_err,
  output logic [1:0]  err_code,
  output logic        busy,
  output logic [15:0] ok_cnt,
  output logic [15:0] err_cnt
);

  localparam logic [31:0] TO_LIMIT = timeout_clks(CLK_FREQ, UART_BPS, TIMEOUT_FRAMES);
  // to_q holds the number of edges since the last byte, so the TO_LIMIT-th
  // idle edge is the one that sees to_q == TO_LIMIT-1.
  localparam logic [31:0] TO_LAST  = TO_LIMIT - 32'd1;
  localparam logic [9:0]  LAST_IDX = 10'(IMG_PIXELS - 1);

  rx_state_e   state_q, state_d;
  err_code_e   err_q, err_d;
  logic [7:0]  chk_q, chk_d;
  logic [9:0]  cnt_q, cnt_d;
  logic [31:0] to_q, to_d;
  logic [7:0]  pix_data_q, pix_data_d;
  logic [9:0]  pix_index_q, pix_index_d;
  logic        pix_valid_q, pix_valid_d;
  logic        start_q, start_d;
  logic        done_q, done_d;
  logic        ferr_q, ferr_d;
  logic        busy_q, busy_d;
  logic        timeout;
  logic        ok_inc, err_inc;

  always_comb begin
    state_d     = state_q;
    err_d       = err_q;
    chk_d       = chk_q;
    cnt_d       = cnt_q;
    to_d        = '0;
    pix_data_d  = pix_data_q;
    pix_index_d = pix_index_q;
    pix_valid_d = 1'b0;
    start_d     = 1'b0;
    done_d      = 1'b0;
    ferr_d      = 1'b0;
    ok_inc      = 1'b0;
    err_inc     = 1'b0;

    timeout = (state_q != S_SYNC0) && !rx_valid && (to_q == TO_LAST);
    if ((state_q != S_SYNC0) && !rx_valid) to_d = to_q + 32'd1;

    if (timeout) begin
      to_d    = '0;
      state_d = S_SYNC0;
      // A lone header byte followed by silence is not a frame, so no error.
      if (state_q != S_SYNC1) begin
        ferr_d  = 1'b1;
        err_d   = ERR_TIMEOUT;
        err_inc = 1'b1;
      end
    end else if (rx_valid) begin
      unique case (state_q)
        S_SYNC0: begin
          if (rx_data == SYNC0) state_d = S_SYNC1;
        end
        S_SYNC1: begin
          if (rx_data == SYNC1) begin
            state_d = S_PAYLOAD;
            start_d = 1'b1;
            chk_d   = '0;
            cnt_d   = '0;
            err_d   = ERR_NONE;
          end else if (rx_data != SYNC0) begin
            state_d = S_SYNC0;
          end
        end
        S_PAYLOAD: begin
          pix_data_d  = rx_data;
          pix_index_d = cnt_q;
          pix_valid_d = 1'b1;
          chk_d       = chk_q + rx_data;
          cnt_d       = cnt_q + 10'd1;
          if (cnt_q == LAST_IDX) state_d = S_CHECK;
        end
        S_CHECK: begin
          if (rx_data == chk_q) begin
            done_d = 1'b1;
            ok_inc = 1'b1;
          end else begin
            ferr_d  = 1'b1;
            err_d   = ERR_CSUM;
            err_inc = 1'b1;
          end
          state_d = S_SYNC0;
        end
        default: state_d = S_SYNC0;
      endcase
    end

    busy_d = (state_d != S_SYNC0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_SYNC0;
      err_q       <= ERR_NONE;
      chk_q       <= '0;
      cnt_q       <= '0;
      to_q        <= '0;
      pix_data_q  <= '0;
      pix_index_q <= '0;
      pix_valid_q <= 1'b0;
      start_q     <= 1'b0;
      done_q      <= 1'b0;
      ferr_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      err_q       <= err_d;
      chk_q       <= chk_d;
      cnt_q       <= cnt_d;
      to_q        <= to_d;
      pix_data_q  <= pix_data_d;
      pix_index_q <= pix_index_d;
      pix_valid_q <= pix_valid_d;
      start_q     <= start_d;
      done_q      <= done_d;
      ferr_q      <= ferr_d;
      busy_q      <= busy_d;
    end
  end

  sat_counter16 u_ok_cnt (
    .clk_i (clk),
    .rst_i (rst),
    .inc_i (ok_inc),
    .cnt_o (ok_cnt)
  );

  sat_counter16 u_err_cnt (
    .clk_i (clk),
    .rst_i (rst),
    .inc_i (err_inc),
    .cnt_o (err_cnt)
  );

  assign pix_data    = pix_data_q;
  assign pix_index   = pix_index_q;
  assign pix_valid   = pix_valid_q;
  assign frame_start = start_q;
  assign frame_done  = done_q;
  assign frame_err   = ferr_q;
  assign err_code    = err_q;
  assign busy        = busy_q;

endmodule
